// File: rtl/arb_rr_lock_timeout_pkg.sv
// ============================================================================
// arb_pkg : shared state encoding and width helpers for arb_rr_lock_timeout
// Rev 1.0
// ============================================================================
`default_nettype none

package arb_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_GRANT  = 2'd1;
    localparam state_t ST_LOCKED = 2'd2;

    localparam int DEF_REQ_NUM  = 4;
    localparam int DEF_MAX_LOCK = 16;

    // clog2 with a floor of one bit so degenerate sizes still give legal vectors
    function automatic int width_of(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/arb_rr_lock_timeout_if.sv
// ============================================================================
// arb_rr_lock_timeout_if : request/lock/grant bundle for the lock arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

interface arb_rr_lock_timeout_if #(
    parameter int REQ_NUM = 4
) ();
    logic [REQ_NUM-1:0] req;
    logic [REQ_NUM-1:0] lockIn;
    logic [REQ_NUM-1:0] grant;
    logic               lockSta;
    logic               lockTimeout;

    modport master (
        output req,
        output lockIn,
        input  grant,
        input  lockSta,
        input  lockTimeout
    );

    modport slave (
        input  req,
        input  lockIn,
        output grant,
        output lockSta,
        output lockTimeout
    );
endinterface

`default_nettype wire

// File: rtl/arb_rr_lock_timeout_rr_pick.sv
// ============================================================================
// rr_pick : combinational rotating-priority picker, first request at or
//           above rr_ptr_i with wrap-around, one-hot result
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_pick
    import arb_pkg::*;
#(
    parameter int REQ_NUM = DEF_REQ_NUM,
    parameter int PTR_W   = width_of(DEF_REQ_NUM)
) (
    input  logic [REQ_NUM-1:0] req_i,
    input  logic [PTR_W-1:0]   rr_ptr_i,
    output logic [REQ_NUM-1:0] winner_o
);

    logic [REQ_NUM-1:0] w_upper;
    logic [REQ_NUM-1:0] w_src;

    // Requests at or above the pointer take precedence; otherwise wrap to all
    always_comb begin
        w_upper = '0;
        for (int j = 0; j < REQ_NUM; j++) begin
            w_upper[j] = req_i[j] && (PTR_W'(j) >= rr_ptr_i);
        end
        w_src    = (|w_upper) ? w_upper : req_i;
        winner_o = w_src & (~w_src + REQ_NUM'(1));
    end

endmodule

`default_nettype wire

// File: rtl/arb_rr_lock_timeout.sv
// ============================================================================
// arb_rr_lock_timeout : round-robin arbiter with owner lock and forced
//                       release after MAX_LOCK locked cycles
// Rev 1.0
// ============================================================================
`default_nettype none

module arb_rr_lock_timeout
    import arb_pkg::*;
#(
    parameter int REQ_NUM  = DEF_REQ_NUM,
    parameter int MAX_LOCK = DEF_MAX_LOCK
) (
    input  logic                 clk,
    input  logic                 rst_n,
    arb_rr_lock_timeout_if.slave bus
);

    localparam int PTR_W = width_of(REQ_NUM);
    localparam int CNT_W = width_of(MAX_LOCK);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(MAX_LOCK - 1);

    state_t             state_q,   state_d;
    logic [REQ_NUM-1:0] grant_q,   grant_d;
    logic [PTR_W-1:0]   rr_ptr_q,  rr_ptr_d;
    logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic               timeout_q, timeout_d;
    logic               ready_q;

    logic [REQ_NUM-1:0] w_win;
    logic [PTR_W-1:0]   w_ptr_nxt;
    logic               w_own_req;
    logic               w_own_lock;

    rr_pick #(
        .REQ_NUM (REQ_NUM),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req_i    (bus.req),
        .rr_ptr_i (rr_ptr_q),
        .winner_o (w_win)
    );

    // Masking with the held grant makes lock/req of non-owners irrelevant
    assign w_own_req  = |(bus.req    & grant_q);
    assign w_own_lock = |(bus.lockIn & grant_q);

    always_comb begin
        w_ptr_nxt = '0;
        for (int j = 0; j < REQ_NUM; j++) begin
            if (w_win[j]) begin
                w_ptr_nxt = (j == REQ_NUM - 1) ? '0 : PTR_W'(j + 1);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        lock_cnt_d = lock_cnt_q;
        timeout_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // The first edge after reset only arms arbitration
                if (ready_q && (|bus.req)) begin
                    grant_d  = w_win;
                    rr_ptr_d = w_ptr_nxt;
                    state_d  = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!w_own_req) begin
                    grant_d = '0;
                    state_d = ST_IDLE;
                end else if (w_own_lock) begin
                    lock_cnt_d = '0;
                    state_d    = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (!w_own_req) begin
                    grant_d = '0;
                    state_d = ST_IDLE;
                end else if (!w_own_lock) begin
                    state_d = ST_GRANT;
                end else if (lock_cnt_q == c_cnt_last) begin
                    grant_d   = '0;
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    lock_cnt_d = lock_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            lock_cnt_q <= '0;
            timeout_q  <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_cnt_q <= lock_cnt_d;
            timeout_q  <= timeout_d;
            ready_q    <= 1'b1;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.lockSta     = (state_q == ST_LOCKED);
    assign bus.lockTimeout = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_arb_rr_lock_timeout.sv
// ============================================================================
// tb_arb_rr_lock_timeout : vector table, directed lock/timeout sequences and
//                          random traffic against a cycle-level reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_arb_rr_lock_timeout;

    localparam int N        = 4;
    localparam int MAX_LOCK = 16;
    localparam int STARVE   = N * (MAX_LOCK + 2);

    logic clk;
    logic rst_n;

    arb_rr_lock_timeout_if #(.REQ_NUM(N)) bus ();

    arb_rr_lock_timeout #(
        .REQ_NUM  (N),
        .MAX_LOCK (MAX_LOCK)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: owner index (-1 = none), cycles spent showing lockSta,
    // cycles the current owner has held the grant, rotating start index
    int m_owner, m_held, m_hold, m_ptr;
    bit m_locked, m_ready, m_tmo;

    task automatic model_update(input logic rstn, input logic [N-1:0] r, input logic [N-1:0] l);
        if (!rstn) begin
            m_owner = -1; m_locked = 0; m_held = 0; m_hold = 0;
            m_ptr = 0; m_ready = 0; m_tmo = 0;
        end else begin
            m_tmo = 0;
            if (m_owner < 0) begin
                if (!m_ready) begin
                    m_ready = 1;
                end else if (r != '0) begin
                    for (int k = 0; k < N; k++) begin
                        int idx;
                        idx = (m_ptr + k) % N;
                        if (m_owner < 0 && r[idx]) m_owner = idx;
                    end
                    m_ptr  = (m_owner + 1) % N;
                    m_hold = 1;
                end
            end else if (!r[m_owner]) begin
                m_owner = -1; m_locked = 0;
            end else if (!m_locked) begin
                if (l[m_owner]) begin
                    m_locked = 1; m_held = 1;
                end
                m_hold++;
            end else if (!l[m_owner]) begin
                m_locked = 0; m_hold++;
            end else if (m_held == MAX_LOCK) begin
                m_owner = -1; m_locked = 0; m_tmo = 1;
            end else begin
                m_held++; m_hold++;
            end
        end
    endtask

    task automatic step(input logic rstn, input logic [N-1:0] r, input logic [N-1:0] l);
        rst_n      = rstn;
        bus.req    = r;
        bus.lockIn = l;
        @(posedge clk);
        model_update(rstn, r, l);
        #1;
    endtask

    task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got grant/lockSta/lockTimeout=%b required=%b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic expect_out(input string name, input logic [N-1:0] g, input logic ls, input logic t);
        check(name, {bus.grant, bus.lockSta, bus.lockTimeout}, {g, ls, t});
    endtask

    typedef struct {
        logic         rstn;
        logic [N-1:0] req;
        logic [N-1:0] lk;
        logic [N-1:0] g;
        logic         ls;
        logic         t;
    } vec_t;

    vec_t tbl[17];

    logic [N-1:0] cur_req, nr, nl;
    logic [N-1:0] exp_g;
    int           wait_cnt[N];
    logic         prev_tmo;
    logic         rr;

    initial begin
        rst_n = 1'b0; bus.req = '0; bus.lockIn = '0;

        // Rotation with bubbles, then non-owner lockIn ignored
        tbl[0]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 4'b1111, 4'b0000, 4'b0001, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 4'b1110, 4'b0000, 4'b0000, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 4'b1110, 4'b0000, 4'b0010, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 4'b1100, 4'b0000, 4'b0000, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 4'b1100, 4'b0000, 4'b0100, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 4'b1000, 4'b0000, 4'b0000, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 4'b1000, 4'b0000, 4'b1000, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 4'b0001, 4'b0000, 4'b0001, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 4'b0010, 4'b0000, 4'b0010, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 4'b0010, 4'b1101, 4'b0010, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 4'b0010, 4'b1101, 4'b0010, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 4'b0010, 4'b0010, 4'b0010, 1'b1, 1'b0};
        tbl[16] = '{1'b1, 4'b0000, 4'b0010, 4'b0000, 1'b0, 1'b0};

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].rstn, tbl[i].req, tbl[i].lk);
            expect_out($sformatf("vec%0d", i), tbl[i].g, tbl[i].ls, tbl[i].t);
        end

        // Full lock run to forced release, then the timed-out source yields
        step(1'b0, 4'b0000, 4'b0000);
        expect_out("to_reset", 4'b0000, 1'b0, 1'b0);
        step(1'b1, 4'b0100, 4'b0100);
        expect_out("to_arm", 4'b0000, 1'b0, 1'b0);
        step(1'b1, 4'b0100, 4'b0100);
        expect_out("to_grant", 4'b0100, 1'b0, 1'b0);
        for (int i = 0; i < MAX_LOCK; i++) begin
            step(1'b1, 4'b0101, 4'b0100);
            expect_out($sformatf("to_locked%0d", i), 4'b0100, 1'b1, 1'b0);
        end
        step(1'b1, 4'b0101, 4'b0100);
        expect_out("to_pulse", 4'b0000, 1'b0, 1'b1);
        step(1'b1, 4'b0101, 4'b0100);
        expect_out("to_next_grant", 4'b0001, 1'b0, 1'b0);
        step(1'b1, 4'b0101, 4'b0100);
        expect_out("to_single_pulse", 4'b0001, 1'b0, 1'b0);

        // Release by lockIn drop at the last count beats the timeout
        step(1'b0, 4'b0000, 4'b0000);
        step(1'b1, 4'b0100, 4'b0100);
        step(1'b1, 4'b0100, 4'b0100);
        expect_out("rel_grant", 4'b0100, 1'b0, 1'b0);
        for (int i = 0; i < MAX_LOCK; i++) begin
            step(1'b1, 4'b0100, 4'b0100);
            expect_out($sformatf("rel_locked%0d", i), 4'b0100, 1'b1, 1'b0);
        end
        step(1'b1, 4'b0100, 4'b0000);
        expect_out("rel_unlock_last", 4'b0100, 1'b0, 1'b0);
        step(1'b1, 4'b0100, 4'b0000);
        expect_out("rel_hold", 4'b0100, 1'b0, 1'b0);

        // Release by req drop at the last count beats the timeout
        for (int i = 0; i < MAX_LOCK; i++) begin
            step(1'b1, 4'b0100, 4'b0100);
            expect_out($sformatf("drop_locked%0d", i), 4'b0100, 1'b1, 1'b0);
        end
        step(1'b1, 4'b0000, 4'b0100);
        expect_out("drop_last", 4'b0000, 1'b0, 1'b0);

        // Reset mid-lock aborts and restores pointer to zero
        step(1'b1, 4'b0100, 4'b0100);
        expect_out("rst_grant", 4'b0100, 1'b0, 1'b0);
        step(1'b1, 4'b0100, 4'b0100);
        step(1'b1, 4'b0100, 4'b0100);
        expect_out("rst_locked", 4'b0100, 1'b1, 1'b0);
        step(1'b0, 4'b0100, 4'b0100);
        expect_out("rst_abort", 4'b0000, 1'b0, 1'b0);
        step(1'b1, 4'b0110, 4'b0000);
        expect_out("rst_arm", 4'b0000, 1'b0, 1'b0);
        step(1'b1, 4'b0110, 4'b0000);
        expect_out("rst_ptr0", 4'b0010, 1'b0, 1'b0);

        // Random traffic against the model plus invariants
        step(1'b0, 4'b0000, 4'b0000);
        cur_req  = '0;
        prev_tmo = 1'b0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (i == m_owner)
                    nr[i] = (m_hold >= MAX_LOCK + 2) ? 1'b0 : ($urandom_range(7) != 0);
                else if (cur_req[i])
                    nr[i] = 1'b1;
                else
                    nr[i] = ($urandom_range(3) == 0);
                nl[i] = ($urandom_range(15) != 0);
            end
            rr = ($urandom_range(511) != 0);
            cur_req = nr;
            step(rr, nr, nl);
            exp_g = '0;
            if (m_owner >= 0) exp_g[m_owner] = 1'b1;
            check("rand_model", {bus.grant, bus.lockSta, bus.lockTimeout}, {exp_g, m_locked, m_tmo});

            n_tests++;
            if (!$onehot0(bus.grant)) begin
                n_fail++;
                $display("FAIL rand_onehot: grant=%b required one-hot-or-zero", bus.grant);
            end
            n_tests++;
            if (prev_tmo && bus.lockTimeout) begin
                n_fail++;
                $display("FAIL rand_pulse: lockTimeout=1 on two consecutive cycles, required single pulse");
            end
            prev_tmo = bus.lockTimeout;
            for (int i = 0; i < N; i++) begin
                wait_cnt[i] = (rr && nr[i] && !bus.grant[i]) ? wait_cnt[i] + 1 : 0;
                if (wait_cnt[i] > STARVE) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rand_starve: source %0d waited %0d cycles, limit %0d", i, wait_cnt[i], STARVE);
                    wait_cnt[i] = 0;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
